// File: rtl/rename_pkg.sv
// rename_pkg: shared rename-path constants and the physical tag type
package rename_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W = $clog2(NUM_PREGS);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/phys_reg_free_list_if.sv
// phys_reg_free_list_if: rename allocate / retire release bundle of the free list
interface phys_reg_free_list_if;
  import rename_pkg::*;
  logic alloc_req;
  logic alloc_valid;
  preg_t alloc_preg;
  logic alloc_grant;
  logic rel_valid;
  preg_t rel_preg;
  logic rel_err;
  logic [PREG_W:0] free_count;
  logic empty;
  logic full;
  modport master (
    output alloc_req, rel_valid, rel_preg,
    input alloc_valid, alloc_preg, alloc_grant, rel_err, free_count, empty, full
  );
  modport slave (
    input alloc_req, rel_valid, rel_preg,
    output alloc_valid, alloc_preg, alloc_grant, rel_err, free_count, empty, full
  );
endinterface

// File: rtl/phys_reg_free_list_tag_ring_fifo.sv
// tag_ring_fifo: first-word-fall-through circular tag buffer with reset-loaded contents
module tag_ring_fifo #(
  parameter int W = 6,
  parameter int DEPTH = 32,
  parameter int BASE = 32,
  parameter int CW = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] wdata,
  input  logic pop,
  output logic [W-1:0] rdata,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  assign rdata = mem[head];
  // pointers wrap at the power-of-two depth; a write at head lands after the combinational read
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= CW'(DEPTH);
      for (int i = 0; i < DEPTH; i++) mem[i] <= W'(BASE + i);
    end else begin
      if (pop) head <= head + AW'(1);
      if (push) begin
        mem[tail] <= wdata;
        tail <= tail + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: free physical-register pool feeding rename and refilled by retire
module phys_reg_free_list
  import rename_pkg::*;
(
  input logic clk,
  input logic rst,
  phys_reg_free_list_if.slave fl
);
  logic grant, push, drop;
  preg_t head_tag;
  logic [PREG_W:0] count;
  assign fl.free_count = count;
  assign fl.alloc_preg = head_tag;
  assign fl.empty = count == '0;
  assign fl.full = count == (PREG_W+1)'(DEPTH);
  assign fl.alloc_valid = !fl.empty;
  assign grant = fl.alloc_req & !fl.empty;
  assign fl.alloc_grant = grant;
  assign push = fl.rel_valid & |fl.rel_preg & (!fl.full | grant);
  assign drop = fl.rel_valid & |fl.rel_preg & fl.full & !grant;
  tag_ring_fifo #(.W(PREG_W), .DEPTH(DEPTH), .BASE(NUM_AREGS), .CW(PREG_W+1)) u_ring (
    .clk(clk),
    .rst(rst),
    .push(push),
    .wdata(fl.rel_preg),
    .pop(grant),
    .rdata(head_tag),
    .count(count)
  );
  // a release dropped on a full pool is flagged for exactly the following cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) fl.rel_err <= 1'b0;
    else fl.rel_err <= drop;
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: randomized and directed checks against a queue model of the free pool
module tb_phys_reg_free_list;
  logic tb_clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int q[$];
  logic exp_err;
  logic cur_req, cur_rv;
  logic [5:0] cur_rp;

  always #5 tb_clk = ~tb_clk;

  phys_reg_free_list_if fl ();
  phys_reg_free_list dut (.clk(tb_clk), .rst(rst_n), .fl(fl.slave));

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    exp_err = 1'b0;
  endtask

  task automatic drive(input logic req, input logic rv, input logic [5:0] rp);
    cur_req = req;
    cur_rv = rv;
    cur_rp = rp;
    fl.alloc_req = req;
    fl.rel_valid = rv;
    fl.rel_preg = rp;
    @(negedge tb_clk);
  endtask

  task automatic tick();
    bit g, a;
    g = cur_req && q.size() > 0;
    a = cur_rv && cur_rp != 0 && (q.size() < 32 || g);
    @(posedge tb_clk);
    if (g) void'(q.pop_front());
    if (a) q.push_back(int'(cur_rp));
    exp_err = cur_rv && cur_rp != 0 && !a;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    fl.alloc_req = 1'b0;
    fl.rel_valid = 1'b0;
    fl.rel_preg = '0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fl.alloc_req = 1'b0;
    fl.rel_valid = 1'b0;
    fl.rel_preg = '0;
    model_reset();
    #2;
    checks++; if (fl.free_count !== 7'd32) begin failures++; $display("FAIL reset_count got=%0d exp=32", fl.free_count); end
    checks++; if (fl.full !== 1'b1 || fl.empty !== 1'b0) begin failures++; $display("FAIL reset_flags got full=%b empty=%b exp full=1 empty=0", fl.full, fl.empty); end
    checks++; if (fl.rel_err !== 1'b0) begin failures++; $display("FAIL reset_rel_err got=%b exp=0", fl.rel_err); end
    checks++; if (fl.alloc_valid !== 1'b1 || fl.alloc_preg !== 6'd32) begin failures++; $display("FAIL reset_head got valid=%b preg=%0d exp valid=1 preg=32", fl.alloc_valid, fl.alloc_preg); end
    rst_n = 1'b1;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 6'd0);
      checks++; if (fl.alloc_grant !== 1'b1 || fl.alloc_preg !== 6'(32 + i)) begin failures++; $display("FAIL drain_grant[%0d] got grant=%b preg=%0d exp grant=1 preg=%0d", i, fl.alloc_grant, fl.alloc_preg, 32 + i); end
      checks++; if (fl.free_count !== 7'(32 - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, fl.free_count, 32 - i); end
      tick();
    end
    drive(1'b1, 1'b0, 6'd0);
    checks++; if (fl.alloc_valid !== 1'b0 || fl.alloc_grant !== 1'b0 || fl.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got valid=%b grant=%b empty=%b exp 0 0 1", fl.alloc_valid, fl.alloc_grant, fl.empty); end
    tick();
  endtask

  task automatic test_release_order();
    int tags[3] = '{5, 40, 17};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 6'(tags[i]));
      tick();
    end
    drive(1'b0, 1'b0, 6'd0);
    checks++; if (fl.free_count !== 7'd3) begin failures++; $display("FAIL release_count got=%0d exp=3", fl.free_count); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 6'd0);
      checks++; if (fl.alloc_grant !== 1'b1 || fl.alloc_preg !== 6'(tags[i])) begin failures++; $display("FAIL release_order[%0d] got grant=%b preg=%0d exp grant=1 preg=%0d", i, fl.alloc_grant, fl.alloc_preg, tags[i]); end
      tick();
    end
  endtask

  task automatic test_empty_simul();
    drive(1'b1, 1'b1, 6'd12);
    checks++; if (fl.alloc_grant !== 1'b0) begin failures++; $display("FAIL empty_simul_grant got=%b exp=0", fl.alloc_grant); end
    tick();
    drive(1'b0, 1'b1, 6'd0);
    checks++; if (fl.free_count !== 7'd1 || fl.alloc_preg !== 6'd12) begin failures++; $display("FAIL empty_simul_push got count=%0d preg=%0d exp count=1 preg=12", fl.free_count, fl.alloc_preg); end
    tick();
    drive(1'b0, 1'b0, 6'd0);
    checks++; if (fl.free_count !== 7'd1 || fl.rel_err !== 1'b0) begin failures++; $display("FAIL x0_release got count=%0d err=%b exp count=1 err=0", fl.free_count, fl.rel_err); end
    tick();
  endtask

  task automatic test_overflow();
    apply_reset();
    drive(1'b0, 1'b1, 6'd9);
    tick();
    drive(1'b0, 1'b0, 6'd0);
    checks++; if (fl.rel_err !== 1'b1 || fl.free_count !== 7'd32) begin failures++; $display("FAIL overflow_drop got err=%b count=%0d exp err=1 count=32", fl.rel_err, fl.free_count); end
    tick();
    drive(1'b0, 1'b0, 6'd0);
    checks++; if (fl.rel_err !== 1'b0) begin failures++; $display("FAIL overflow_pulse got err=%b exp=0", fl.rel_err); end
    tick();
  endtask

  task automatic test_full_simul();
    drive(1'b1, 1'b1, 6'd9);
    checks++; if (fl.alloc_grant !== 1'b1 || fl.alloc_preg !== 6'd32) begin failures++; $display("FAIL full_simul_grant got grant=%b preg=%0d exp grant=1 preg=32", fl.alloc_grant, fl.alloc_preg); end
    tick();
    drive(1'b0, 1'b0, 6'd0);
    checks++; if (fl.free_count !== 7'd32 || fl.rel_err !== 1'b0) begin failures++; $display("FAIL full_simul_state got count=%0d err=%b exp count=32 err=0", fl.free_count, fl.rel_err); end
    tick();
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 1'b0, 6'd0);
      checks++; if (fl.alloc_preg !== 6'(q[0])) begin failures++; $display("FAIL full_simul_pop[%0d] got=%0d exp=%0d", i, fl.alloc_preg, q[0]); end
      tick();
    end
    drive(1'b1, 1'b0, 6'd0);
    checks++; if (fl.alloc_grant !== 1'b1 || fl.alloc_preg !== 6'd9) begin failures++; $display("FAIL full_simul_tail got grant=%b preg=%0d exp grant=1 preg=9", fl.alloc_grant, fl.alloc_preg); end
    tick();
  endtask

  task automatic test_random_wrap();
    for (int i = 0; i < 100; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      checks++; if (fl.alloc_grant !== (cur_req && q.size() > 0)) begin failures++; $display("FAIL rand_grant[%0d] got=%b exp=%b", i, fl.alloc_grant, cur_req && q.size() > 0); end
      checks++; if (fl.free_count !== 7'(q.size())) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, fl.free_count, q.size()); end
      checks++; if (fl.rel_err !== exp_err) begin failures++; $display("FAIL rand_err[%0d] got=%b exp=%b", i, fl.rel_err, exp_err); end
      if (q.size() > 0) begin
        checks++; if (fl.alloc_preg !== 6'(q[0])) begin failures++; $display("FAIL rand_preg[%0d] got=%0d exp=%0d", i, fl.alloc_preg, q[0]); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 6'd0);
      tick();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (fl.free_count !== 7'd32 || fl.full !== 1'b1 || fl.rel_err !== 1'b0 || fl.alloc_preg !== 6'd32) begin failures++; $display("FAIL async_reset got count=%0d full=%b err=%b preg=%0d exp 32 1 0 32", fl.free_count, fl.full, fl.rel_err, fl.alloc_preg); end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 6'd0);
    checks++; if (fl.alloc_grant !== 1'b1 || fl.alloc_preg !== 6'd32) begin failures++; $display("FAIL async_first_grant got grant=%b preg=%0d exp grant=1 preg=32", fl.alloc_grant, fl.alloc_preg); end
    tick();
  endtask

  initial begin
    fl.alloc_req = 1'b0;
    fl.rel_valid = 1'b0;
    fl.rel_preg = '0;
    @(posedge tb_clk);
    #1;
    test_reset();
    test_drain();
    test_release_order();
    test_empty_simul();
    test_overflow();
    test_full_simul();
    test_random_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Physical-register free list for the out-of-order core.
- The rename stage pops a free physical register for each destination (rrd). The retire stage pushes back the previous mapping of each committed destination.
- It is the release/return end of the rename allocation path.
- Implemented as a circular FIFO of physical-register tags with head/tail pointers and an occupancy counter.

Parameters:
- NUM_PREGS, 64, total physical registers.
- NUM_AREGS, 32, architectural registers. Pregs 0..NUM_AREGS-1 are mapped at reset.
- PREG_W, 6, physical tag width; equals log2(NUM_PREGS).
- DEPTH, NUM_PREGS-NUM_AREGS (32), FIFO capacity; the maximum number of simultaneously free pregs.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- alloc_req  in  1  rename requests one preg this cycle.
- alloc_valid  out  1  a free preg is available (not empty).
- alloc_preg  out  PREG_W  tag at head; valid when alloc_valid.
- alloc_grant  out  1  alloc_req & alloc_valid; the pop occurs this edge.
- rel_valid  in  1  retire returns one preg.
- rel_preg  in  PREG_W  tag being returned.
- rel_err  out  1  registered one-cycle pulse: a release was dropped (overflow).
- free_count  out  PREG_W+1  current occupancy, 0..DEPTH.
- empty  out  1  free_count==0.
- full  out  1  free_count==DEPTH.

Behaviour:
- Reset (rst low, async):
  - head=0, tail=0, free_count=DEPTH, full=1, empty=0, rel_err=0.
  - Storage entry i = NUM_AREGS+i for i in 0..DEPTH-1, so pregs 32..63 are free.
  - Reset mid-operation discards all in-flight state immediately. The first pop after reset returns 32.
- Read path is first-word-fall-through: alloc_preg = mem[head] combinationally, with no read latency.
- Pop: on a posedge with alloc_req & !empty, head <= head+1 mod DEPTH.
- Pop on empty: alloc_req with empty=1 is ignored. No grant, no state change, no error. Rename must stall on !alloc_valid.
- Push: on a posedge with an accepted release, mem[tail] <= rel_preg and tail <= tail+1 mod DEPTH.
- Release accept rule:
  - Accepted if rel_valid & rel_preg!=0 & (!full | alloc_grant).
  - rel_preg==0 (x0 mapping, never renamed) is silently ignored with no error.
- Overflow: rel_valid & rel_preg!=0 & full & !alloc_grant drops the release. rel_err=1 for the next cycle only.
- Counter: free_count <= free_count + accepted_push - alloc_grant.
  - Simultaneous pop and push leaves the count unchanged.
- Simultaneous push and pop when full:
  - Legal; head==tail.
  - The combinational read returns the old mem[head]. The write lands at the same index at the edge, so read happens before write.
- Simultaneous push and pop when empty: the pop is not granted (no bypass of rel_preg to alloc_preg). The push is accepted, giving free_count=1 next cycle.
- Wrap-around: both pointers are PREG_W-1 bits wide and wrap naturally at DEPTH (a power of two). full/empty are derived from free_count, not from pointer compare.
- No duplicate detection: retire guarantees each tag is returned at most once.

Decomposition:
- Shared package, rename_pkg:
  - NUM_PREGS, NUM_AREGS, PREG_W, DEPTH constants.
  - preg_t typedef (logic [PREG_W-1:0]).
  - Also used by the rename map table and ROB.
- One natural sub-module, tag_ring_fifo: generic FWFT circular buffer with reset-initialised contents, push/pop, and count.
  - phys_reg_free_list wraps it with the x0 filter, the accept rule, and rel_err generation.

Test Plan:
- Reset then 32 consecutive alloc_req cycles:
  - Grants return 32,33,...,63 in order.
  - free_count steps 32→0.
  - On the 33rd cycle alloc_valid=0, alloc_grant=0 and empty=1.
- After draining, release 5, 40, 17 on three cycles:
  - free_count=3.
  - Subsequent pops return 5, 40, 17 in order.
- Full (post-reset), rel_valid with rel_preg=9 and no alloc:
  - Dropped; rel_err=1 for exactly one cycle; free_count stays 32.
- Full, alloc_req with rel_valid=1 and rel_preg=9 in the same cycle:
  - alloc_preg=32 granted; free_count stays 32; no rel_err.
  - After 31 more pops, the next grant returns 9.
- Empty, alloc_req with rel_valid=1 and rel_preg=12 in the same cycle:
  - No grant; next cycle free_count=1, alloc_preg=12.
  - Release of rel_preg=0 leaves free_count unchanged and rel_err=0.
- Wrap and reset:
  - Run 100 random balanced push/pop cycles crossing the index 31→0 wrap. A scoreboard queue must match alloc_preg exactly.
  - Assert rst low between edges: outputs return to reset values immediately, then the first grant returns 32.
